// File: rtl/fetch_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : fetch_pkg                                              |
// | Description : Shared types and constants for the fetch stage.        |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
package fetch_pkg;

  // Fetch FSM: issue request, wait for response, hold a stalled word
  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_e;

  localparam int          OPCODE_W     = 7;
  localparam logic [31:0] BUBBLE_INSTR = 32'h0000_0000;
  localparam logic [31:0] PC_STEP      = 32'd4;

endpackage
`default_nettype wire

// File: rtl/fetch_stage_if_id_reg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : if_id_reg                                              |
// | Description : IF/ID pipeline register. Bubble beats load, load beats |
// |               hold. A bubble is {valid=0, pc=0, instr=0}.            |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module if_id_reg
  import fetch_pkg::*;
(
  input  logic                clk_i,
  input  logic                rstn_i,
  input  logic                load_i,
  input  logic                bubble_i,
  input  logic [31:0]         pc_i,
  input  logic [31:0]         instr_i,
  output logic                valid_o,
  output logic [31:0]         pc_o,
  output logic [31:0]         instr_o,
  output logic [OPCODE_W-1:0] opcode_o
);

  logic        valid_q;
  logic [31:0] pc_q;
  logic [31:0] instr_q;

  // Pipeline register: bubble on flush or idle, load on delivery, else hold
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      valid_q <= 1'b0;
      pc_q    <= 32'h0;
      instr_q <= BUBBLE_INSTR;
    end else if (bubble_i) begin
      valid_q <= 1'b0;
      pc_q    <= 32'h0;
      instr_q <= BUBBLE_INSTR;
    end else if (load_i) begin
      valid_q <= 1'b1;
      pc_q    <= pc_i;
      instr_q <= instr_i;
    end
  end

  assign valid_o  = valid_q;
  assign pc_o     = pc_q;
  assign instr_o  = instr_q;
  assign opcode_o = instr_q[OPCODE_W-1:0];

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : fetch_stage                                            |
// | Description : Instruction fetch with single-outstanding imem access, |
// |               skid buffer for stalled decode and redirect flushing.  |
// |               Optional macro FETCH_PERF_EN adds perf_wait_cycles.    |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rstn,
  output logic                imem_req,
  output logic [31:0]         imem_addr,
  input  logic                imem_rvalid,
  input  logic [31:0]         imem_rdata,
  input  logic                stall,
  input  logic                redirect,
  input  logic [31:0]         redirect_pc,
  output logic                if_id_valid,
  output logic [31:0]         if_id_pc,
  output logic [31:0]         if_id_instr,
  output logic [OPCODE_W-1:0] if_id_opcode
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]         perf_wait_cycles
`endif
);

  fetch_state_e state_q;
  logic [31:0]  pc_q;
  logic         kill_q;
  logic [31:0]  skid_q;

  logic         deliver_wait;
  logic         deliver_hold;
  logic         ifid_load;
  logic         ifid_bubble;
  logic [31:0]  ifid_instr_d;

  assign imem_req  = (state_q == S_REQ) && !redirect;
  assign imem_addr = pc_q;

  // A word reaches IF/ID only when decode accepts and no redirect flushes it
  assign deliver_wait = (state_q == S_WAIT) && imem_rvalid && !kill_q
                        && !stall && !redirect;
  assign deliver_hold = (state_q == S_HOLD) && !stall && !redirect;
  assign ifid_load    = deliver_wait || deliver_hold;
  assign ifid_bubble  = redirect || (!stall && !ifid_load);
  assign ifid_instr_d = (state_q == S_HOLD) ? skid_q : imem_rdata;

  // Fetch FSM, PC, kill flag and skid buffer; redirect overrides everything
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      kill_q  <= 1'b0;
      skid_q  <= 32'h0;
    end else if (redirect) begin
      // Low address bits are dropped so fetches stay word aligned
      pc_q <= redirect_pc & ~32'h3;
      unique case (state_q)
        S_WAIT: begin
          if (imem_rvalid) begin
            state_q <= S_REQ;
            kill_q  <= 1'b0;
          end else begin
            kill_q  <= 1'b1;
          end
        end
        S_HOLD:  state_q <= S_REQ;
        default: state_q <= S_REQ;
      endcase
    end else begin
      unique case (state_q)
        S_REQ: begin
          if (imem_req) state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            if (kill_q) begin
              kill_q  <= 1'b0;
              state_q <= S_REQ;
            end else if (!stall) begin
              pc_q    <= pc_q + PC_STEP;
              state_q <= S_REQ;
            end else begin
              skid_q  <= imem_rdata;
              state_q <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (!stall) begin
            pc_q    <= pc_q + PC_STEP;
            state_q <= S_REQ;
          end
        end
        default: state_q <= S_REQ;
      endcase
    end
  end

  if_id_reg u_if_id_reg (
    .clk_i    (clk),
    .rstn_i   (rstn),
    .load_i   (ifid_load),
    .bubble_i (ifid_bubble),
    .pc_i     (pc_q),
    .instr_i  (ifid_instr_d),
    .valid_o  (if_id_valid),
    .pc_o     (if_id_pc),
    .instr_o  (if_id_instr),
    .opcode_o (if_id_opcode)
  );

`ifdef FETCH_PERF_EN
  logic [31:0] perf_q;

  // Count every cycle spent waiting on memory or on decode
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      perf_q <= 32'h0;
    end else if (state_q == S_WAIT || state_q == S_HOLD) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_wait_cycles = perf_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_fetch_stage                                         |
// | Description : Directed self-checking bench for fetch_stage. A second |
// |               instance with RESET_PC=FFFF_FFFC shares the stimulus.  |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module tb_fetch_stage;

  logic        clk;
  logic        rstn;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;

  logic        imem_req,    imem_req2;
  logic [31:0] imem_addr,   imem_addr2;
  logic        if_id_valid, if_id_valid2;
  logic [31:0] if_id_pc,    if_id_pc2;
  logic [31:0] if_id_instr, if_id_instr2;
  logic [6:0]  if_id_opcode, if_id_opcode2;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_wait_cycles, perf_wait_cycles2;
`endif

  int total;
  int bad;

  fetch_stage #(.RESET_PC(32'h0000_0000)) u_dut (
    .clk          (clk),
    .rstn         (rstn),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .stall        (stall),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .if_id_valid  (if_id_valid),
    .if_id_pc     (if_id_pc),
    .if_id_instr  (if_id_instr),
    .if_id_opcode (if_id_opcode)
`ifdef FETCH_PERF_EN
    ,
    .perf_wait_cycles (perf_wait_cycles)
`endif
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) u_dut_wrap (
    .clk          (clk),
    .rstn         (rstn),
    .imem_req     (imem_req2),
    .imem_addr    (imem_addr2),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .stall        (stall),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .if_id_valid  (if_id_valid2),
    .if_id_pc     (if_id_pc2),
    .if_id_instr  (if_id_instr2),
    .if_id_opcode (if_id_opcode2)
`ifdef FETCH_PERF_EN
    ,
    .perf_wait_cycles (perf_wait_cycles2)
`endif
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: count, and report any mismatch
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Advance to 1 ns after the next rising edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total       = 0;
    bad         = 0;
    rstn        = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;

    // Reset state
    cyc(); cyc();
    #1;
    check("rst_valid",  {31'h0, if_id_valid}, 32'h0);
    check("rst_pc",     if_id_pc,             32'h0);
    check("rst_instr",  if_id_instr,          32'h0);
    check("rst_opcode", {25'h0, if_id_opcode}, 32'h0);
    check("rst_addr",   imem_addr,            32'h0);
`ifdef FETCH_PERF_EN
    check("rst_perf",   perf_wait_cycles,     32'h0);
`endif

    // First fetch: request cycle 1, response cycle 2, IF/ID valid cycle 3
    cyc();
    rstn = 1'b1;
    #1;
    check("c1_req",   {31'h0, imem_req}, 32'h1);
    check("c1_addr",  imem_addr,         32'h0);
    check("wrap_c1_addr", imem_addr2,    32'hFFFF_FFFC);
    cyc();
    check("c2_req",   {31'h0, imem_req}, 32'h0);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0000_0013;
    cyc();
    imem_rvalid = 1'b0;
    #1;
    check("c3_valid",  {31'h0, if_id_valid}, 32'h1);
    check("c3_opcode", {25'h0, if_id_opcode}, 32'h13);
    check("c3_pc",     if_id_pc,             32'h0);
    check("c3_next_addr", imem_addr,         32'h4);
    check("c3_next_req",  {31'h0, imem_req}, 32'h1);
    check("wrap_valid",   {31'h0, if_id_valid2}, 32'h1);
    check("wrap_pc",      if_id_pc2,         32'hFFFF_FFFC);
    check("wrap_next_addr", imem_addr2,      32'h0);

    // Stall across response: word parks in skid, IF/ID holds old value
    stall = 1'b1;
    cyc();                                   // -> S_WAIT, IF/ID held
    check("st_hold0_valid", {31'h0, if_id_valid}, 32'h1);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0050_0093;
    cyc();                                   // -> S_HOLD
    imem_rvalid = 1'b0;
    #1;
    check("st_hold1_instr", if_id_instr,        32'h0000_0013);
    check("st_hold1_req",   {31'h0, imem_req},  32'h0);
    cyc();                                   // still S_HOLD
    check("st_hold2_instr", if_id_instr,        32'h0000_0013);
    check("st_hold2_addr",  imem_addr,          32'h4);
    stall = 1'b0;
    cyc();                                   // skid word delivered
    #1;
    check("st_rel_valid", {31'h0, if_id_valid}, 32'h1);
    check("st_rel_pc",    if_id_pc,             32'h4);
    check("st_rel_instr", if_id_instr,          32'h0050_0093);
    check("st_rel_addr",  imem_addr,            32'h8);
    check("st_rel_req",   {31'h0, imem_req},    32'h1);

    // Redirect in S_WAIT, stale response two cycles later is dropped
    cyc();                                   // -> S_WAIT at 8, IF/ID bubble
    check("rd_bubble_valid", {31'h0, if_id_valid}, 32'h0);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0103;
    cyc();                                   // kill set, pc=0x100
    redirect = 1'b0;
    #1;
    check("rd_kill_req",  {31'h0, imem_req}, 32'h0);
    check("rd_kill_addr", imem_addr,         32'h100);
    cyc();
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    cyc();                                   // dropped, back to S_REQ
    imem_rvalid = 1'b0;
    #1;
    check("rd_drop_valid", {31'h0, if_id_valid}, 32'h0);
    check("rd_drop_instr", if_id_instr,          32'h0);
    check("rd_drop_addr",  imem_addr,            32'h100);
    check("rd_drop_req",   {31'h0, imem_req},    32'h1);

    // Redirect together with rvalid and stall: flush, no S_HOLD
    cyc();                                   // -> S_WAIT at 0x100
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0000_0033;
    cyc();                                   // IF/ID = {1,0x100,0x33}
    imem_rvalid = 1'b0;
    stall = 1'b1;
    #1;
    check("rs_pre_pc", if_id_pc, 32'h100);
    cyc();                                   // -> S_WAIT at 0x104, held
    check("rs_pre_hold", {31'h0, if_id_valid}, 32'h1);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0000_0073;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0200;
    #1;
    check("rs_req_suppr", {31'h0, imem_req}, 32'h0);
    cyc();
    imem_rvalid = 1'b0;
    redirect    = 1'b0;
    #1;
    check("rs_flush_valid", {31'h0, if_id_valid}, 32'h0);
    check("rs_flush_instr", if_id_instr,          32'h0);
    check("rs_next_req",    {31'h0, imem_req},    32'h1);
    check("rs_next_addr",   imem_addr,            32'h200);

    // Reset pulse mid-request, stray response after release is ignored
    stall = 1'b0;
    cyc();                                   // -> S_WAIT at 0x200
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0000_0063;
    cyc();                                   // IF/ID valid at 0x200
    imem_rvalid = 1'b0;
    stall = 1'b1;
    cyc();                                   // -> S_WAIT at 0x204
    check("ar_pre_valid", {31'h0, if_id_valid}, 32'h1);
    rstn = 1'b0;
    #1;
    check("ar_valid",  {31'h0, if_id_valid}, 32'h0);
    check("ar_pc",     if_id_pc,             32'h0);
    check("ar_instr",  if_id_instr,          32'h0);
    check("ar_opcode", {25'h0, if_id_opcode}, 32'h0);
    check("ar_addr",   imem_addr,            32'h0);
    cyc();
    rstn        = 1'b1;
    stall       = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hFFFF_FFFF;
    cyc();                                   // stray rvalid in S_REQ
    imem_rvalid = 1'b0;
    #1;
    check("ar_stray_valid", {31'h0, if_id_valid}, 32'h0);
    check("ar_stray_instr", if_id_instr,          32'h0);
    check("ar_stray_addr",  imem_addr,            32'h0);
    check("ar_stray_req",   {31'h0, imem_req},    32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
